// File: rtl/regfile_wr_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wr_arb_if
// Description : Bundle of the pipeline write-back port, the multi-cycle unit
//               write port and the arbitrated register-file write port.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wr_arb_if;
  // Pipeline write-back side (no backpressure)
  logic        p_we;
  logic [4:0]  p_waddr;
  logic [31:0] p_wdata;
  // Multi-cycle unit side (valid/ready)
  logic        m_valid;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic        m_ready;
  // Register file write port
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  // Pipeline control / status
  logic        stall_req;
  logic        pend_valid;
  logic [4:0]  pend_addr;
  logic        overrun;

  modport master (
    output p_we, p_waddr, p_wdata,
    output m_valid, m_waddr, m_wdata,
    input  m_ready,
    input  we, waddr, wdata,
    input  stall_req, pend_valid, pend_addr, overrun
  );

  modport slave (
    input  p_we, p_waddr, p_wdata,
    input  m_valid, m_waddr, m_wdata,
    output m_ready,
    output we, waddr, wdata,
    output stall_req, pend_valid, pend_addr, overrun
  );
endinterface
`default_nettype wire

// File: rtl/regfile_wr_arb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wr_arb
// Description : Register-file write arbiter. The pipeline write-back always
//               wins; a single-entry holding register buffers a multi-cycle
//               unit write until a free cycle. Sustained starvation of the
//               held entry raises a registered stall request to the pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wr_arb #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  regfile_wr_arb_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_FORCE = 2'd2
  } state_t;

  // Denial count at which the next denial forces a stall
  localparam logic [3:0] C_CNT_LAST = 4'(STARVE_MAX - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;

  logic        r_hv;
  logic [4:0]  r_ha;
  logic [31:0] r_hd;
  logic        r_overrun;

  logic        w_p_act;
  logic        w_m_ready;
  logic        w_capture;
  logic        w_grant;

  logic        w_we;
  logic [4:0]  w_waddr;
  logic [31:0] w_wdata;

  // Reset gates the combinational outputs so nothing escapes while rst is low,
  // even if the pipeline keeps p_we asserted.
  assign w_p_act   = rst & bus.p_we & (bus.p_waddr != 5'd0);
  assign w_m_ready = rst & ~r_hv;
  // A transfer to r0 completes the handshake but stores nothing.
  assign w_capture = bus.m_valid & w_m_ready & (bus.m_waddr != 5'd0);
  assign w_grant   = r_hv & ~w_p_act;

  // State and starvation counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: count denials of the held entry, force a stall at the limit
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = 4'd0;
        if (w_capture) begin
          w_state_nxt = ST_PEND;
        end
      end
      ST_PEND: begin
        if (w_grant) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 4'd0;
        end else if (r_cnt == C_CNT_LAST) begin
          w_state_nxt = ST_FORCE;
          w_cnt_nxt   = r_cnt + 4'd1;
        end else begin
          w_cnt_nxt   = r_cnt + 4'd1;
        end
      end
      ST_FORCE: begin
        // Counter saturates here; only a grant leaves FORCE.
        if (w_grant) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 4'd0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Holding register: capture an accepted M write, drop it once granted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hv <= 1'b0;
      r_ha <= 5'd0;
      r_hd <= 32'd0;
    end else if (w_capture) begin
      r_hv <= 1'b1;
      r_ha <= bus.m_waddr;
      r_hd <= bus.m_wdata;
    end else if (w_grant) begin
      // Clearing the address keeps pend_addr at zero while nothing is held.
      r_hv <= 1'b0;
      r_ha <= 5'd0;
      r_hd <= 32'd0;
    end
  end

  // Sticky overrun: the pipeline wrote back while it was told to freeze
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overrun <= 1'b0;
    end else if (bus.p_we && (r_state == ST_FORCE)) begin
      r_overrun <= 1'b1;
    end
  end

  // Write port mux: pipeline first, then the held entry, otherwise idle zeros
  always_comb begin
    w_we    = 1'b0;
    w_waddr = 5'd0;
    w_wdata = 32'd0;
    if (w_p_act) begin
      w_we    = 1'b1;
      w_waddr = bus.p_waddr;
      w_wdata = bus.p_wdata;
    end else if (r_hv) begin
      w_we    = 1'b1;
      w_waddr = r_ha;
      w_wdata = r_hd;
    end
  end

  assign bus.m_ready    = w_m_ready;
  assign bus.we         = w_we;
  assign bus.waddr      = w_waddr;
  assign bus.wdata      = w_wdata;
  assign bus.stall_req  = (r_state == ST_FORCE);
  assign bus.pend_valid = r_hv;
  assign bus.pend_addr  = r_hv ? r_ha : 5'd0;
  assign bus.overrun    = r_overrun;

endmodule
`default_nettype wire

// File: doc/regfile_wr_arb.md
REGFILE_WR_ARB -- requirements
Module: regfile_wr_arb

Interface
REQ-001 The block SHALL have parameter STARVE_MAX, default 4, legal range 1..15: the maximum number of consecutive cycles a held M-side write is denied before a pipeline stall is forced.
REQ-002 The block SHALL have one clock and one reset; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 p_we  in  1  pipeline write-back request; has no backpressure and is never dropped.
REQ-006 p_waddr  in  5  pipeline write address.
REQ-007 p_wdata  in  32  pipeline write data.
REQ-008 m_valid  in  1  multi-cycle unit write request.
REQ-009 m_waddr  in  5  multi-cycle unit write address.
REQ-010 m_wdata  in  32  multi-cycle unit write data.
REQ-011 m_ready  out  1  M-side accept; an M write transfers on a rising edge where m_valid=1 and m_ready=1.
REQ-012 we  out  1  register file write enable.
REQ-013 waddr  out  5  register file write address.
REQ-014 wdata  out  32  register file write data.
REQ-015 stall_req  out  1  registered request for the pipeline to freeze write-back.
REQ-016 pend_valid  out  1  held M write is pending; drives the decode interlock.
REQ-017 pend_addr  out  5  address of the held M write.
REQ-018 overrun  out  1  sticky error flag: p_we asserted while stall_req=1.

Function
REQ-019 Holding register (hv, ha, hd) SHALL be one entry; m_ready SHALL equal ~hv (0 while rst=0).
REQ-020 On an M transfer with m_waddr!=0, the block SHALL capture hv<=1, ha<=m_waddr, hd<=m_wdata.
REQ-021 On an M transfer with m_waddr==0, the handshake SHALL complete, nothing SHALL be stored, and hv SHALL stay 0.
REQ-022 p_act SHALL be defined as p_we & (p_waddr!=0), and grant SHALL be defined as hv & ~p_act.
REQ-023 Write port outputs SHALL be combinational and mutually exclusive by source.
 - If p_act: we=1, waddr=p_waddr, wdata=p_wdata.
 - Else if hv: we=1, waddr=ha, wdata=hd.
 - Else: we=0, waddr=0, wdata=0.
REQ-024 A pipeline write to r0 SHALL be discarded and SHALL NOT block the held entry.
REQ-025 On a rising edge with grant=1, hv SHALL clear; a new M transfer cannot occur in that same edge, because m_ready=0.
REQ-026 The FSM SHALL have states IDLE (hv=0), PEND (hv=1, counting) and FORCE (stall_req=1).
REQ-027 FSM transitions SHALL be:
 - IDLE->PEND on an M transfer with nonzero address.
 - PEND->IDLE on grant.
 - PEND->PEND on denial, with cnt+1.
 - PEND->FORCE on denial when cnt==STARVE_MAX-1.
 - FORCE->IDLE on grant.
 - FORCE->FORCE while denied.
REQ-028 cnt SHALL be 4 bits, SHALL clear on entering IDLE, and SHALL saturate in FORCE.
REQ-029 stall_req SHALL be 1 exactly while the state is FORCE; the pipeline holds p_we=0 while stall_req=1, so the grant occurs in the first FORCE cycle.
REQ-030 If p_act=1 in FORCE, P SHALL still win, the state SHALL stay FORCE, and overrun SHALL set and hold until reset.
REQ-031 pend_valid SHALL equal hv and pend_addr SHALL equal ha; pend_addr SHALL be 0 when hv=0.
REQ-032 When p_act and a grant target the same address in different cycles, the write order SHALL be the grant order; same-cycle ordering hazards are the decoder's job, using pend_*.

Reset
REQ-033 While rst=0, the block SHALL hold hv=0, ha=0, hd=0, state=IDLE, cnt=0, stall_req=0, overrun=0, m_ready=0 and we=0.
REQ-034 On rst falling mid-operation, a held entry SHALL be discarded, with no write issued.
REQ-035 The first rising edge after rst rises SHALL behave as IDLE with m_ready=1.

Verification
REQ-036 Single M write: p_we=0; M transfers waddr=5, data=0xDEADBEEF -> next cycle we=1, waddr=5, wdata=0xDEADBEEF, pend_valid=1; the following cycle hv=0 and m_ready=1.
REQ-037 Collision: hv holds r7; p_we=1, p_waddr=3, p_wdata=0x11 -> we shows r3/0x11; the r7 write issues in the first cycle with p_we=0.
REQ-038 Starvation: STARVE_MAX=4; hv=1; p_we=1 to r9 every cycle -> stall_req=1 after 4 denials; p_we then 0 -> r7 written and stall_req=0 the next cycle.
REQ-039 r0 handling, two cases:
 - M transfer to r0 -> no write and pend_valid stays 0.
 - p_we=1 with p_waddr=0 while hv=1 -> held entry written that cycle.
REQ-040 Overrun: in FORCE, drive p_we=1 to r4 -> P written, state stays FORCE, overrun=1 until rst=0.
REQ-041 Reset mid-pend: hv=1 and rst driven 0 asynchronously -> we, pend_valid and m_ready go to 0 immediately; no held write appears after release.
